// File: rtl/viterbi_ctrl_pkg.sv
// Shared definitions for the Viterbi decoder controller.
package viterbi_ctrl_pkg;

   localparam int SYM_W      = 2;  // received symbol width (rate-1/2 code)
   localparam int DEF_TAIL   = 2;  // K=3 trellis needs K-1 zero flush symbols
   localparam int DEF_DP_LAT = 2;  // BMU->PMU->SMU step-to-decision latency

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/viterbi_ctrl_dly.sv
// Tag delay line: marks which datapath steps carried a payload symbol so the
// matching SMU decision can be flagged when it emerges DEPTH cycles later.
module viterbi_ctrl_dly
   import viterbi_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DP_LAT
) (
   input  logic clk,
   input  logic rst,
   input  logic tag_in,
   output logic tag_out
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   // shift the newest tag in at bit 0
   always_comb begin
      sr_d = (sr_q << 1) | DEPTH'(tag_in);
   end

   // tag register, cleared by the controller reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign tag_out = sr_q[DEPTH-1];

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the Viterbi decoder: feeds payload symbols to the BMU,
// flushes the trellis with zero symbols, drains the pipeline and flags each
// decoded payload bit as it leaves the SMU.
module viterbi_ctrl
   import viterbi_ctrl_pkg::*;
#(
   parameter int FRAME_W = 8,
   parameter int TAIL    = DEF_TAIL,
   parameter int DP_LAT  = DEF_DP_LAT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame_len,
   input  logic               sym_valid,
   input  logic [SYM_W-1:0]   sym_in,
   output logic               sym_ready,
   output logic [SYM_W-1:0]   dec_in,
   output logic               sel0,
   output logic [1:0]         sel1,
   output logic               dp_en,
   output logic               dp_rst,
   input  logic [SYM_W-1:0]   smu_out,
   output logic               bit_valid,
   output logic               bit_out,
   output logic               busy,
   output logic               done
);

   localparam int PH_W = 8;

   state_e             state_q, state_d;
   logic [FRAME_W-1:0] len_q, len_d;
   logic [FRAME_W-1:0] stage_q, stage_d;
   logic [FRAME_W-1:0] out_cnt_q, out_cnt_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [SYM_W-1:0]   dec_q, dec_d;
   logic               dp_rst_q, dp_rst_d;
   logic               step_tag;
   logic               tag_out;
   logic               smu_hi_unused;

   // next-state, counters and datapath strobes
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      stage_d   = stage_q;
      out_cnt_d = out_cnt_q;
      phase_d   = phase_q;
      sym_ready = 1'b0;
      dp_en     = 1'b0;
      dec_in    = dec_q;
      sel0      = 1'b0;
      step_tag  = 1'b0;
      done      = 1'b0;
      busy      = (state_q != ST_IDLE);
      if (bit_valid) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d   = frame_len;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            stage_d   = '0;
            out_cnt_d = '0;
            phase_d   = '0;
            dec_in    = '0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            sym_ready = 1'b1;
            if (sym_valid) begin
               dp_en    = 1'b1;
               dec_in   = sym_in;
               step_tag = 1'b1;
               sel0     = (stage_q == '0);
               stage_d  = stage_q + 1'b1;
               if (stage_d == len_q) begin
                  phase_d = '0;
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            dp_en  = 1'b1;
            dec_in = '0;
            if (phase_q == PH_W'(TAIL - 1)) begin
               phase_d = '0;
               state_d = ST_DRAIN;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            dp_en  = 1'b1;
            dec_in = '0;
            // counts the bit arriving this cycle so the exit does not lag by one
            if (phase_q == PH_W'(DP_LAT - 1)) begin
               if (out_cnt_d == len_q) begin
                  state_d = ST_DONE;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      dec_d    = dec_in;
      dp_rst_d = (state_d != ST_CLEAR);
   end

   // state and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         stage_q   <= '0;
         out_cnt_q <= '0;
         phase_q   <= '0;
         dec_q     <= '0;
         dp_rst_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         stage_q   <= stage_d;
         out_cnt_q <= out_cnt_d;
         phase_q   <= phase_d;
         dec_q     <= dec_d;
         dp_rst_q  <= dp_rst_d;
      end
   end

   viterbi_ctrl_dly #(
      .DEPTH (DP_LAT)
   ) u_dly (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (step_tag),
      .tag_out (tag_out)
   );

   assign sel1          = stage_q[1:0];
   assign dp_rst        = dp_rst_q;
   assign bit_valid     = tag_out;
   assign bit_out       = tag_out & smu_out[0];
   assign smu_hi_unused = smu_out[1];

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl with a two-cycle stand-in for the datapath.
module tb_viterbi_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] frame_len;
   logic       sym_valid;
   logic [1:0] sym_in;
   logic       sym_ready;
   logic [1:0] dec_in;
   logic       sel0;
   logic [1:0] sel1;
   logic       dp_en;
   logic       dp_rst;
   logic [1:0] smu_out;
   logic       bit_valid;
   logic       bit_out;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   viterbi_ctrl #(
      .FRAME_W (8),
      .TAIL    (2),
      .DP_LAT  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .sym_valid (sym_valid),
      .sym_in    (sym_in),
      .sym_ready (sym_ready),
      .dec_in    (dec_in),
      .sel0      (sel0),
      .sel1      (sel1),
      .dp_en     (dp_en),
      .dp_rst    (dp_rst),
      .smu_out   (smu_out),
      .bit_valid (bit_valid),
      .bit_out   (bit_out),
      .busy      (busy),
      .done      (done)
   );

   // datapath stand-in: decision equals the symbol driven two cycles earlier
   logic [1:0] p0, p1;
   always @(posedge clk) begin
      p0 <= dec_in;
      p1 <= p0;
   end
   assign smu_out = p1;

   int errors = 0;
   int checks = 0;

   int          cyc;
   int          done_cyc;
   int          done_n;
   int          nbits;
   logic [15:0] bits_v;
   logic [15:0] sel1_v;
   logic [15:0] sel0_v;
   int          stall_n;
   int          stall_dp;
   logic [7:0]  stall_sel1_v;
   logic [7:0]  stall_dec_v;
   int          tail_n;
   int          tail_nz;
   int          post_busy;
   logic        accepted;
   logic [1:0]  syms [8];

   function automatic logic [11:0] out_vec();
      return {sym_ready, dec_in, sel0, sel1, dp_en, dp_rst, bit_valid, bit_out, busy, done};
   endfunction

   // one clock: inputs already driven at the negedge, sample 1 ns later
   task automatic tick();
      #1;
      accepted = sym_ready && sym_valid;
      if (bit_valid) begin
         nbits++;
         bits_v = {bits_v[14:0], bit_out};
      end
      if (sym_ready && dp_en) begin
         sel1_v = {sel1_v[13:0], sel1};
         sel0_v = {sel0_v[14:0], sel0};
      end
      if (sym_ready && !sym_valid) begin
         stall_n++;
         if (dp_en) stall_dp++;
         stall_sel1_v = {stall_sel1_v[5:0], sel1};
         stall_dec_v  = {stall_dec_v[5:0], dec_in};
      end
      if (busy && dp_en && !sym_ready) begin
         tail_n++;
         if (dec_in != 2'b00) tail_nz++;
      end
      if (done) begin
         done_n++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_frame(input int len, input int gap_after, input int gap_len,
                            input int start_a, input int start_b);
      int idx = 0;
      int gap_left = 0;
      cyc = 0; done_cyc = -1; done_n = 0; nbits = 0;
      bits_v = '0; sel1_v = '0; sel0_v = '0;
      stall_n = 0; stall_dp = 0; stall_sel1_v = '0; stall_dec_v = '0;
      tail_n = 0; tail_nz = 0; post_busy = 0;
      frame_len = 8'(len);
      while (done_cyc < 0 && cyc < 100) begin
         start = (cyc == 0) || (cyc == start_a) || (cyc == start_b);
         if (gap_left > 0) begin
            sym_valid = 1'b0;
         end else if (idx < len) begin
            sym_valid = 1'b1;
            sym_in    = syms[idx];
         end else begin
            sym_valid = 1'b0;
         end
         tick();
         if (accepted) begin
            idx++;
            if (idx == gap_after) gap_left = gap_len;
         end else if (gap_left > 0 && sym_ready) begin
            gap_left--;
         end
      end
      start = 1'b0;
      sym_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (busy) post_busy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; frame_len = '0; sym_valid = 1'b0; sym_in = '0;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (out_vec() !== 12'h000)
         begin errors++; $display("FAIL reset_outputs: got %h want 000", out_vec()); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (dp_rst !== 1'b0)
         begin errors++; $display("FAIL dp_rst_at_release: got %b want 0", dp_rst); end
      @(negedge clk);
      #1;
      checks++;
      if ({dp_rst, busy} !== 2'b10)
         begin errors++; $display("FAIL idle_after_reset: dp_rst,busy got %b want 10", {dp_rst, busy}); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(4, 0, 0, -1, -1);
      checks++;
      if (nbits !== 4) begin errors++; $display("FAIL basic_nbits: got %0d want 4", nbits); end
      checks++;
      if (bits_v[3:0] !== 4'b1001) begin errors++; $display("FAIL basic_bits: got %b want 1001", bits_v[3:0]); end
      checks++;
      if (sel1_v[7:0] !== 8'h1B) begin errors++; $display("FAIL basic_sel1: got %h want 1b", sel1_v[7:0]); end
      checks++;
      if (sel0_v[3:0] !== 4'b1000) begin errors++; $display("FAIL basic_sel0: got %b want 1000", sel0_v[3:0]); end
      checks++;
      if (done_cyc !== 10) begin errors++; $display("FAIL basic_done_cycle: got %0d want 10", done_cyc); end
      checks++;
      if (done_n !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_n); end
      checks++;
      if ({tail_n, tail_nz} !== {32'd4, 32'd0})
         begin errors++; $display("FAIL basic_tail: steps %0d nonzero %0d want 4 0", tail_n, tail_nz); end
      checks++;
      if (post_busy !== 0) begin errors++; $display("FAIL basic_idle_after: busy cycles %0d want 0", post_busy); end
   endtask

   task automatic test_stall();
      syms = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(3, 1, 2, -1, -1);
      checks++;
      if (nbits !== 3) begin errors++; $display("FAIL stall_nbits: got %0d want 3", nbits); end
      checks++;
      if (bits_v[2:0] !== 3'b110) begin errors++; $display("FAIL stall_bits: got %b want 110", bits_v[2:0]); end
      checks++;
      if ({stall_n, stall_dp} !== {32'd2, 32'd0})
         begin errors++; $display("FAIL stall_dp_en: stalls %0d with dp_en %0d want 2 0", stall_n, stall_dp); end
      checks++;
      if (stall_sel1_v[3:0] !== 4'b0101) begin errors++; $display("FAIL stall_sel1_hold: got %b want 0101", stall_sel1_v[3:0]); end
      checks++;
      if (stall_dec_v[3:0] !== 4'b0101) begin errors++; $display("FAIL stall_dec_hold: got %b want 0101", stall_dec_v[3:0]); end
      checks++;
      if (done_cyc !== 11) begin errors++; $display("FAIL stall_done_cycle: got %0d want 11", done_cyc); end
   endtask

   task automatic test_wrap();
      syms = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
      run_frame(6, 0, 0, -1, -1);
      checks++;
      if (sel1_v[11:0] !== 12'h1B1) begin errors++; $display("FAIL wrap_sel1: got %h want 1b1", sel1_v[11:0]); end
      checks++;
      if ({tail_n, tail_nz} !== {32'd4, 32'd0})
         begin errors++; $display("FAIL wrap_flush: steps %0d nonzero %0d want 4 0", tail_n, tail_nz); end
      checks++;
      if (nbits !== 6) begin errors++; $display("FAIL wrap_nbits: got %0d want 6", nbits); end
      checks++;
      if (bits_v[5:0] !== 6'b011010) begin errors++; $display("FAIL wrap_bits: got %b want 011010", bits_v[5:0]); end
      checks++;
      if (done_cyc !== 12) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 12", done_cyc); end
   endtask

   task automatic test_reset_mid_run();
      frame_len = 8'd5; start = 1'b1; sym_valid = 1'b1; sym_in = 2'b11;
      tick();
      start = 1'b0;
      tick();
      tick();
      sym_in = 2'b01;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (out_vec() !== 12'h000)
         begin errors++; $display("FAIL midrun_reset_outputs: got %h want 000", out_vec()); end
      sym_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (dp_rst !== 1'b0) begin errors++; $display("FAIL midrun_dp_rst_release: got %b want 0", dp_rst); end
      @(negedge clk);
      #1;
      checks++;
      if ({dp_rst, busy} !== 2'b10)
         begin errors++; $display("FAIL midrun_idle: dp_rst,busy got %b want 10", {dp_rst, busy}); end
      @(negedge clk);
      syms = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(5, 0, 0, -1, -1);
      checks++;
      if (nbits !== 5) begin errors++; $display("FAIL midrun_next_nbits: got %0d want 5", nbits); end
      checks++;
      if (bits_v[4:0] !== 5'b11010) begin errors++; $display("FAIL midrun_next_bits: got %b want 11010", bits_v[4:0]); end
      checks++;
      if (done_cyc !== 11) begin errors++; $display("FAIL midrun_next_done: got %0d want 11", done_cyc); end
   endtask

   task automatic test_start_ignored();
      syms = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      run_frame(1, 0, 0, 2, 7);
      checks++;
      if (nbits !== 1) begin errors++; $display("FAIL len1_nbits: got %0d want 1", nbits); end
      checks++;
      if (bits_v[0] !== 1'b1) begin errors++; $display("FAIL len1_bit: got %b want 1", bits_v[0]); end
      checks++;
      if (done_cyc !== 7) begin errors++; $display("FAIL len1_done_cycle: got %0d want 7", done_cyc); end
      checks++;
      if (done_n !== 1) begin errors++; $display("FAIL len1_done_pulses: got %0d want 1", done_n); end
      checks++;
      if (post_busy !== 0) begin errors++; $display("FAIL start_in_done_ignored: busy cycles %0d want 0", post_busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_reset_mid_run();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter FRAME_W, default 8: width of the frame-length and stage counters.
REQ-002 Parameter TAIL, default 2: number of zero flush symbols (K=3, 4-state trellis).
REQ-003 Parameter DP_LAT, default 2: cycles from a dp_en step to the matching smu_out bit.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle frame start; sampled only in IDLE.
REQ-007 frame_len  in  FRAME_W  payload symbol count, latched on start; 0 is illegal.
REQ-008 sym_valid / sym_in  in  1 / 2  upstream received-symbol handshake.
REQ-009 sym_ready  out  1  ctrl accepts sym_in this cycle.
REQ-010 dec_in  out  2  symbol driven to the BMU.
REQ-011 sel0  out  1  PMU initial-metric select, 1 on the first trellis step only.
REQ-012 sel1  out  2  PMU stage select, equals stage counter[1:0].
REQ-013 dp_en  out  1  datapath step strobe; BMU/PMU/SMU advance only when 1.
REQ-014 dp_rst  out  1  active-low datapath clear.
REQ-015 smu_out  in  2  SMU decision output.
REQ-016 bit_valid / bit_out  out  1 / 1  decoded-bit strobe and value.
REQ-017 busy / done  out  1 / 1  frame in progress / one-cycle frame-complete pulse.

Function
REQ-018 States IDLE, CLEAR, RUN, FLUSH, DRAIN, DONE; one-hot or binary encoding is free.
REQ-019 IDLE->CLEAR on start; CLEAR lasts exactly 1 cycle with dp_rst=0, stage counter and output counter zeroed.
REQ-020 CLEAR->RUN unconditionally; in RUN sym_ready=1 and dp_en=sym_valid, dec_in=sym_in.
REQ-021 sym_valid=0 in RUN stalls: dp_en=0, counters hold, dec_in holds previous value.
REQ-022 Each accepted symbol increments the stage counter (wraps at 2^FRAME_W); sel0=1 only when stage counter=0 and dp_en=1.
REQ-023 RUN->FLUSH on the cycle frame_len symbols have been accepted; FLUSH drives dec_in=00, dp_en=1, sym_ready=0 for exactly TAIL cycles.
REQ-024 FLUSH->DRAIN; DRAIN keeps dp_en=1, dec_in=00 for DP_LAT cycles so the pipeline empties.
REQ-025 bit_valid=1 exactly DP_LAT cycles after each dp_en=1 step of a payload symbol, bit_out=smu_out[0]; tail and drain steps produce no bit_valid.
REQ-026 Exactly frame_len bit_valid pulses occur per frame, in symbol order, including across stalls.
REQ-027 DRAIN->DONE when the output counter equals frame_len; done=1 for 1 cycle, then IDLE.
REQ-028 busy=1 in every state except IDLE; start while busy is ignored.
REQ-029 start asserted in the DONE cycle is ignored; a new frame needs start in IDLE.

Reset
REQ-030 rst=0 forces IDLE asynchronously at any point, including mid-frame; partial frame output is abandoned.
REQ-031 Reset values: sym_ready=0, dec_in=00, sel0=0, sel1=00, dp_en=0, dp_rst=0, bit_valid=0, bit_out=0, busy=0, done=0.
REQ-032 dp_rst stays 0 while rst=0 and returns to 1 in the first IDLE cycle after release.

Structure
REQ-033 Shared package holds the state enum, TAIL, DP_LAT and the symbol width (2).
REQ-034 One sub-module, viterbi_ctrl_dly: DP_LAT-deep shift register of a payload-step tag aligning bit_valid with smu_out.
REQ-035 viterbi_ctrl instantiates alongside bmu/pmu/smu at the decoder top level; datapath modules are not modified except for dp_en gating.

Verification
REQ-036 frame_len=4, sym_in 11,10,00,01 back-to-back -> sel0=1 on step 1 only, sel1 0,1,2,3, 4 bit_valid pulses, done 4+TAIL+DP_LAT+2 cycles after start.
REQ-037 frame_len=3 with sym_valid low 2 cycles between symbols 1 and 2 -> dp_en=0 during the gap, sel1 holds, still exactly 3 bit_valid.
REQ-038 frame_len=6 -> sel1 wraps 0,1,2,3,0,1; FLUSH drives dec_in=00 for 2 cycles with sym_ready=0.
REQ-039 rst=0 during RUN after 2 of 5 symbols -> all outputs at reset values same cycle; next start runs a clean 5-symbol frame.
REQ-040 start pulsed during RUN and in DONE -> ignored, no second frame; frame_len=1 -> single bit_valid then done.
